// File: rtl/glitch_pkg.sv
// Shared state encoding and default widths for the glitcher timing core.
package glitch_pkg;

   localparam int DEF_DELAY_W = 32;
   localparam int DEF_WIDTH_W = 16;
   localparam int DEF_COUNT_W = 8;
   localparam int DEF_RST_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TRESET = 3'd1,
      ST_ARMED  = 3'd2,
      ST_DELAY  = 3'd3,
      ST_PULSE  = 3'd4,
      ST_GAP    = 3'd5
   } state_t;

endpackage

// File: rtl/trigger_sync.sv
// Two-flop synchronizer plus previous-value flop; emits a single-cycle edge
// pulse of the selected polarity.
module trigger_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic fall,
   output logic edge_pulse
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign edge_pulse = fall ? (~sync2 & prev) : (sync2 & ~prev);

endmodule

// File: rtl/glitch_sequencer.sv
// Glitcher timing core: optional target reset, arm, trigger edge, programmable
// delay, then a burst of width/gap pulses. All timing in clk cycles.
module glitch_sequencer
   import glitch_pkg::*;
#(
   parameter int DELAY_W = DEF_DELAY_W,
   parameter int WIDTH_W = DEF_WIDTH_W,
   parameter int COUNT_W = DEF_COUNT_W,
   parameter int RST_W   = DEF_RST_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic [WIDTH_W-1:0] cfg_width,
   input  logic [WIDTH_W-1:0] cfg_gap,
   input  logic [COUNT_W-1:0] cfg_count,
   input  logic [RST_W-1:0]   cfg_rst_len,
   input  logic               cfg_trig_fall,
   input  logic               cmd_arm,
   input  logic               cmd_reset_target,
   input  logic               cmd_abort,
   input  logic               trigger_i,
   output logic               pulse_o,
   output logic               target_reset_o,
   output logic               busy_o,
   output logic               armed_o,
   output logic               done_o,
   output logic [2:0]         state_dbg
);

   state_t             state;
   logic [DELAY_W-1:0] lat_delay, delay_cnt;
   logic [WIDTH_W-1:0] lat_width, lat_gap, width_cnt, gap_cnt;
   logic [COUNT_W-1:0] lat_count, pulse_left;
   logic [RST_W-1:0]   rst_cnt;
   logic               lat_fall;
   logic               arm_pending;
   logic               trig_edge;
   logic               arm_ok;

   trigger_sync u_trigger_sync (
      .clk        (clk),
      .rst        (rst),
      .din        (trigger_i),
      .fall       (lat_fall),
      .edge_pulse (trig_edge)
   );

   assign arm_ok    = cmd_arm && (cfg_count != '0);
   assign busy_o    = (state != ST_IDLE);
   assign armed_o   = (state == ST_ARMED);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         pulse_o        <= 1'b0;
         target_reset_o <= 1'b0;
         done_o         <= 1'b0;
         arm_pending    <= 1'b0;
         lat_delay      <= '0;
         lat_width      <= '0;
         lat_gap        <= '0;
         lat_count      <= '0;
         lat_fall       <= 1'b0;
         delay_cnt      <= '0;
         width_cnt      <= '0;
         gap_cnt        <= '0;
         pulse_left     <= '0;
         rst_cnt        <= '0;
      end else begin
         done_o <= 1'b0;
         if (cmd_abort && state != ST_IDLE) begin
            state          <= ST_IDLE;
            pulse_o        <= 1'b0;
            target_reset_o <= 1'b0;
            arm_pending    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  // Latch config once so later cfg_* writes cannot disturb a run.
                  if (cmd_reset_target || arm_ok) begin
                     lat_delay <= cfg_delay;
                     lat_width <= (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
                     lat_gap   <= (cfg_gap == '0) ? WIDTH_W'(1) : cfg_gap;
                     lat_count <= cfg_count;
                     lat_fall  <= cfg_trig_fall;
                  end
                  if (cmd_reset_target) begin
                     state          <= ST_TRESET;
                     target_reset_o <= 1'b1;
                     rst_cnt        <= (cfg_rst_len == '0) ? RST_W'(1) : cfg_rst_len;
                     arm_pending    <= arm_ok;
                  end else if (arm_ok) begin
                     state <= ST_ARMED;
                  end
               end
               ST_TRESET: begin
                  if (rst_cnt == RST_W'(1)) begin
                     target_reset_o <= 1'b0;
                     arm_pending    <= 1'b0;
                     state          <= arm_pending ? ST_ARMED : ST_IDLE;
                  end else begin
                     rst_cnt <= rst_cnt - RST_W'(1);
                  end
               end
               ST_ARMED: begin
                  if (trig_edge) begin
                     pulse_left <= lat_count;
                     if (lat_delay == '0) begin
                        state     <= ST_PULSE;
                        pulse_o   <= 1'b1;
                        width_cnt <= lat_width;
                     end else begin
                        state     <= ST_DELAY;
                        delay_cnt <= lat_delay;
                     end
                  end
               end
               ST_DELAY: begin
                  if (delay_cnt == DELAY_W'(1)) begin
                     state     <= ST_PULSE;
                     pulse_o   <= 1'b1;
                     width_cnt <= lat_width;
                  end else begin
                     delay_cnt <= delay_cnt - DELAY_W'(1);
                  end
               end
               ST_PULSE: begin
                  if (width_cnt == WIDTH_W'(1)) begin
                     pulse_o <= 1'b0;
                     if (pulse_left > COUNT_W'(1)) begin
                        state      <= ST_GAP;
                        gap_cnt    <= lat_gap;
                        pulse_left <= pulse_left - COUNT_W'(1);
                     end else begin
                        state  <= ST_IDLE;
                        done_o <= 1'b1;
                     end
                  end else begin
                     width_cnt <= width_cnt - WIDTH_W'(1);
                  end
               end
               ST_GAP: begin
                  if (gap_cnt == WIDTH_W'(1)) begin
                     state     <= ST_PULSE;
                     pulse_o   <= 1'b1;
                     width_cnt <= lat_width;
                  end else begin
                     gap_cnt <= gap_cnt - WIDTH_W'(1);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: per-scenario tasks push expected
// output vectors {pulse, target_reset, busy, armed, done} and compare per cycle.
module tb_glitch_sequencer;

   localparam int W = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cfg_delay = '0;
   logic [15:0] cfg_width = '0;
   logic [15:0] cfg_gap = '0;
   logic [7:0]  cfg_count = '0;
   logic [15:0] cfg_rst_len = '0;
   logic        cfg_trig_fall = 1'b0;
   logic        cmd_arm = 1'b0;
   logic        cmd_reset_target = 1'b0;
   logic        cmd_abort = 1'b0;
   logic        trigger_i = 1'b0;
   logic        pulse_o, target_reset_o, busy_o, armed_o, done_o;
   logic [2:0]  state_dbg;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs, exp_v;
   int vectors = 0;
   int errors  = 0;

   glitch_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_delay        (cfg_delay),
      .cfg_width        (cfg_width),
      .cfg_gap          (cfg_gap),
      .cfg_count        (cfg_count),
      .cfg_rst_len      (cfg_rst_len),
      .cfg_trig_fall    (cfg_trig_fall),
      .cmd_arm          (cmd_arm),
      .cmd_reset_target (cmd_reset_target),
      .cmd_abort        (cmd_abort),
      .trigger_i        (trigger_i),
      .pulse_o          (pulse_o),
      .target_reset_o   (target_reset_o),
      .busy_o           (busy_o),
      .armed_o          (armed_o),
      .done_o           (done_o),
      .state_dbg        (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_low();
      trigger_i = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      vectors++;
      if (state_dbg !== 3'd0) begin
         errors++;
         $display("FAIL reset_state got %0d want 0", state_dbg);
      end
      for (int j = 0; j < 12; j++) exp_q.push_back(5'b00000);
      for (int j = 0; j < 12; j++) begin
         trigger_i = (j % 3 == 1);
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_idle j=%0d got %b want %b", j, obs, exp_v);
         end
      end
   endtask

   task automatic test_delay();
      settle_low();
      cfg_delay = 32'd10; cfg_width = 16'd3; cfg_gap = 16'd1; cfg_count = 8'd1;
      cfg_trig_fall = 1'b0;
      cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
      for (int j = 0; j < 19; j++)
         exp_q.push_back({(j >= 12 && j <= 14), 1'b0, (j < 15), (j < 2), (j == 15)});
      for (int j = 0; j < 19; j++) begin
         if (j == 0) trigger_i = 1'b1;
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL delay j=%0d got %b want %b", j, obs, exp_v);
         end
      end
   endtask

   task automatic test_burst();
      logic p;
      settle_low();
      cfg_delay = 32'd0; cfg_width = 16'd2; cfg_gap = 16'd4; cfg_count = 8'd3;
      cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
      for (int j = 0; j < 22; j++) begin
         p = 1'b0;
         for (int n = 0; n < 3; n++) if (j >= 2 + 6 * n && j <= 3 + 6 * n) p = 1'b1;
         exp_q.push_back({p, 1'b0, (j < 16), (j < 2), (j == 16)});
      end
      for (int j = 0; j < 22; j++) begin
         if (j == 0) trigger_i = 1'b1;
         if (j == 5) trigger_i = 1'b0;
         if (j == 8) trigger_i = 1'b1;
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL burst j=%0d got %b want %b", j, obs, exp_v);
         end
      end
   endtask

   task automatic test_reset_and_arm();
      trigger_i = 1'b1;
      repeat (4) tick();
      cfg_delay = 32'd0; cfg_width = 16'd1; cfg_count = 8'd1;
      cfg_rst_len = 16'd5; cfg_trig_fall = 1'b1;
      for (int j = 0; j < 15; j++)
         exp_q.push_back({(j == 10), (j < 5), (j <= 10), (j >= 5 && j <= 9), (j == 11)});
      for (int j = 0; j < 15; j++) begin
         cmd_reset_target = (j == 0);
         cmd_arm = (j == 0);
         if (j == 8) trigger_i = 1'b0;
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL treset_arm j=%0d got %b want %b", j, obs, exp_v);
         end
      end
      cmd_reset_target = 1'b0;
      cmd_arm = 1'b0;
   endtask

   task automatic test_abort();
      settle_low();
      cfg_delay = 32'd100; cfg_width = 16'd2; cfg_count = 8'd1; cfg_trig_fall = 1'b0;
      cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
      for (int j = 0; j < 130; j++) exp_q.push_back({1'b0, 1'b0, (j < 6), (j < 2), 1'b0});
      for (int j = 0; j < 130; j++) begin
         if (j == 0) trigger_i = 1'b1;
         cmd_abort = (j == 6);
         if (j == 40) trigger_i = 1'b0;
         if (j == 50) trigger_i = 1'b1;
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL abort j=%0d got %b want %b", j, obs, exp_v);
         end
      end
      cmd_abort = 1'b0;
   endtask

   task automatic test_count_zero();
      settle_low();
      cfg_count = 8'd0; cfg_delay = 32'd0; cfg_width = 16'd1;
      for (int j = 0; j < 6; j++) exp_q.push_back(5'b00000);
      for (int j = 0; j < 6; j++) begin
         cmd_arm = (j == 0);
         if (j == 3) trigger_i = 1'b1;
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL count_zero j=%0d got %b want %b", j, obs, exp_v);
         end
      end
      cmd_arm = 1'b0;
   endtask

   task automatic test_width_zero();
      settle_low();
      cfg_delay = 32'd1; cfg_width = 16'd0; cfg_gap = 16'd0; cfg_count = 8'd1;
      cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
      for (int j = 0; j < 8; j++)
         exp_q.push_back({(j == 3), 1'b0, (j < 4), (j < 2), (j == 4)});
      for (int j = 0; j < 8; j++) begin
         if (j == 0) trigger_i = 1'b1;
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL width_zero j=%0d got %b want %b", j, obs, exp_v);
         end
      end
   endtask

   task automatic test_trigger_high_at_arm();
      trigger_i = 1'b1;
      repeat (4) tick();
      cfg_delay = 32'd0; cfg_width = 16'd1; cfg_count = 8'd1;
      cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
      for (int j = 0; j < 21; j++)
         exp_q.push_back({(j == 16), 1'b0, (j < 17), (j < 16), (j == 17)});
      for (int j = 0; j < 21; j++) begin
         if (j == 10) trigger_i = 1'b0;
         if (j == 14) trigger_i = 1'b1;
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL trig_high_arm j=%0d got %b want %b", j, obs, exp_v);
         end
      end
   endtask

   task automatic test_rst_mid();
      settle_low();
      cfg_delay = 32'd0; cfg_width = 16'd20; cfg_count = 8'd1;
      cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
      for (int j = 0; j < 12; j++)
         exp_q.push_back({(j >= 2 && j < 8), 1'b0, (j < 8), (j < 2), 1'b0});
      for (int j = 0; j < 12; j++) begin
         if (j == 0) trigger_i = 1'b1;
         rst = (j == 8);
         tick();
         obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
         exp_v = exp_q.pop_front();
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_mid j=%0d got %b want %b", j, obs, exp_v);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_delay();
      test_burst();
      test_reset_and_arm();
      test_abort();
      test_count_zero();
      test_width_zero();
      test_trigger_high_at_arm();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
